run_sequencer: RTL and testbench
================================

# run_sequencer

Host-facing run controller for the single-cycle core. It holds the core in reset while idle and gives the host exclusive access to the data memory for loading operands and reading results. On a host request it releases the core and times the run. It detects program completion or a cycle-budget timeout and answers the host with a four-phase req/done handshake. It sits between the test host and the core top level, driving the core reset and multiplexing the data-memory write/address port.

## Interface
Parameters:
- RST_CYC, 2: number of cycles the core reset is held after a request, before run (≥1)
- CW, 16: cycle-counter width
- MAX_CYC, 16'd4000: run-cycle budget; reaching it forces timeout (≤ 2^CW−1)
- AW, 8: data-memory address width

Ports:
- clk in 1: system clock
- reset in 1: asynchronous, active-high; one clock, all state in this domain
- req in 1: host start request, level (four-phase)
- core_done in 1: core end-of-program flag
- core_rst out 1: reset to core (PC, flags)
- run out 1: core executing
- done out 1: run finished (normal or timeout)
- timeout out 1: run ended by budget exhaustion
- cycles out CW: run-cycle count of last/current run
- host_gnt out 1: host owns data memory
- host_we in 1, host_addr in AW, host_wdat in 8: host memory write/address port
- core_we in 1, core_addr in AW, core_wdat in 8: core memory port
- mem_we out 1, mem_addr out AW, mem_wdat out 8: to data memory

## Operation
- States: IDLE, CRST, RUN, FIN, TOUT. State is registered.
- Outputs are decoded from state:
  - core_rst = IDLE|CRST|FIN|TOUT
  - run = RUN
  - done = FIN|TOUT
  - timeout = TOUT
  - host_gnt = IDLE|FIN|TOUT
- IDLE: if req=1 → CRST, clear cycles, load the reset counter with RST_CYC−1.
- CRST: decrement the reset counter; at 0 → RUN. CRST lasts exactly RST_CYC cycles.
- RUN, evaluated in priority order each cycle:
  - core_done=1 → FIN; cycles holds and that cycle is not counted.
  - Else if cycles == MAX_CYC−1 → TOUT; cycles becomes MAX_CYC.
  - Else cycles += 1.
- core_done and budget exhaustion in the same cycle: FIN wins, timeout=0.
- FIN / TOUT: hold until req=0, then → IDLE. cycles keeps its value until the next request.
- req high in CRST/RUN is ignored. A req drop mid-run does not abort the run. A new run needs req low (observed in FIN/TOUT) and then high again.
- Memory mux (combinational):
  - host_gnt=1: mem_* = host_*.
  - RUN: mem_* = core_*.
  - CRST: mem_we=0, mem_addr = core_addr.
  - Writes from the non-owner are dropped, never queued.
- cycles never wraps; it saturates at MAX_CYC.
- core_done is ignored outside RUN. It is expected high while the core sits in reset at a stale PC.

## Timing
- Reset values:
  - state IDLE
  - core_rst=1, run=0, done=0, timeout=0
  - cycles=0
  - host_gnt=1
  - mem_we = host_we (combinational)
- Asserting reset in any state forces these values immediately. The core is re-held in reset and any run in progress is abandoned.
- req sampled high at edge k: CRST from k, run=1 from edge k+RST_CYC. The first core instruction executes in the cycle after edge k+RST_CYC.
- core_done high in cycle ending at edge m: done=1 and core_rst=1 from edge m.
- req low sampled at edge n in FIN/TOUT: done=0 from edge n.
- Minimum request-to-done latency: RST_CYC+1 edges.
- Mux outputs are combinational from registered state, so there is no extra latency on the memory path.

## Test plan
- Reset: assert reset mid-cycle → core_rst=1, done=0, cycles=0, host_gnt=1 before the next edge. host_we=1, host_addr=8'h10, host_wdat=8'hA5 → mem_* mirrors host.
- Normal run, RST_CYC=2: req high at edge 0 → run=1 at edge 2. core_done at the 10th RUN cycle → cycles=9, done=1, host_gnt=1. Drop req → IDLE the next edge.
- Ownership: during RUN drive host_we=1 → mem_we follows core_we only. During CRST, core_we=1 → mem_we=0.
- Timeout, MAX_CYC=20, core_done never asserted → TOUT after 20 RUN cycles with cycles=20, timeout=1, done=1. core_done at cycle 20 instead → FIN, timeout=0.
- Handshake: keep req high through FIN for 5 cycles → no restart. Then req low 1 cycle, high again → new CRST, cycles cleared.
- Reset during RUN with cycles=7 → IDLE, cycles=0, run=0 asynchronously. A subsequent req starts a full CRST of RST_CYC cycles.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: host-facing run controller for the single-cycle core.
// Holds the core in reset while idle, grants the host the data-memory port,
// releases and times a run on request, and reports completion or timeout
// with a four-phase req/done handshake.
// Ports:
//   clk, reset           : clock, async active-high reset
//   req                  : host start request (level, four-phase)
//   core_done            : core end-of-program flag (used only in RUN)
//   core_rst, run        : core reset / core executing
//   done, timeout        : run finished / finished by budget exhaustion
//   cycles               : run-cycle count of last/current run
//   host_gnt             : host owns data memory
//   host_we/addr/wdat    : host memory port
//   core_we/addr/wdat    : core memory port
//   mem_we/addr/wdat     : muxed data-memory port
module run_sequencer #(
  parameter int unsigned    RST_CYC = 2,
  parameter int unsigned    CW      = 16,
  parameter logic [CW-1:0]  MAX_CYC = CW'(4000),
  parameter int unsigned    AW      = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  output logic          core_rst,
  output logic          run,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic          host_gnt,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdat,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_wdat,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdat
);

  localparam int unsigned RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CRST = 3'd1,
    RUN  = 3'd2,
    FIN  = 3'd3,
    TOUT = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [RW-1:0] rcnt, rcnt_d;
  logic [CW-1:0] cycles_d;

  // State, counters and state-decoded flags; flags are registered from the
  // next state so they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rcnt     <= '0;
      cycles   <= '0;
      core_rst <= 1'b1;
      run      <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      host_gnt <= 1'b1;
    end else begin
      state    <= state_d;
      rcnt     <= rcnt_d;
      cycles   <= cycles_d;
      core_rst <= (state_d != RUN);
      run      <= (state_d == RUN);
      done     <= (state_d == FIN) || (state_d == TOUT);
      timeout  <= (state_d == TOUT);
      host_gnt <= (state_d == IDLE) || (state_d == FIN) || (state_d == TOUT);
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d  = state;
    rcnt_d   = rcnt;
    cycles_d = cycles;
    case (state)
      IDLE: begin
        if (req) begin
          state_d  = CRST;
          cycles_d = '0;
          rcnt_d   = RW'(RST_CYC - 1);
        end
      end
      CRST: begin
        if (rcnt == '0) state_d = RUN;
        else            rcnt_d  = rcnt - RW'(1);
      end
      RUN: begin
        // Completion beats budget exhaustion; the done cycle is not counted.
        if (core_done) begin
          state_d = FIN;
        end else if (cycles == MAX_CYC - CW'(1)) begin
          state_d  = TOUT;
          cycles_d = MAX_CYC;
        end else begin
          cycles_d = cycles + CW'(1);
        end
      end
      FIN, TOUT: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port mux: host when granted, core while running, and during core
  // reset the address follows the core but writes are blocked.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = core_addr;
    mem_wdat = core_wdat;
    if (host_gnt) begin
      mem_we   = host_we;
      mem_addr = host_addr;
      mem_wdat = host_wdat;
    end else if (run) begin
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_wdat = core_wdat;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboarded bench for run_sequencer (RST_CYC=2,
// MAX_CYC=20). Stimulus pushes the expected run result when a run starts;
// a monitor pops it on each rising edge of done.
module tb_run_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic          to;
    logic [CW-1:0] cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, core_done;
  logic          core_rst, run, done, timeout, host_gnt;
  logic [CW-1:0] cycles;
  logic          host_we, core_we, mem_we;
  logic [AW-1:0] host_addr, core_addr, mem_addr;
  logic [7:0]    host_wdat, core_wdat, mem_wdat;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  exp_t sb[$];
  logic done_q = 1'b0;

  run_sequencer #(.RST_CYC(2), .CW(CW), .MAX_CYC(16'd20), .AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .core_done(core_done),
    .core_rst(core_rst), .run(run), .done(done), .timeout(timeout),
    .cycles(cycles), .host_gnt(host_gnt),
    .host_we(host_we), .host_addr(host_addr), .host_wdat(host_wdat),
    .core_we(core_we), .core_addr(core_addr), .core_wdat(core_wdat),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each new done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset) begin
      done_q = 1'b0;
    end else begin
      if (done && !done_q) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_timeout", 32'(timeout), 32'(e.to));
          check("sb_cycles", 32'(cycles), 32'(e.cyc));
        end
      end
      done_q = done;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; core_done = 1'b1;
    host_we = 1'b1; host_addr = 8'h10; host_wdat = 8'hA5;
    core_we = 1'b0; core_addr = 8'h33; core_wdat = 8'h5C;
    #2;
    // Reset values and host-owned memory path.
    check("rst_core_rst", 32'(core_rst), 32'(1));
    check("rst_run", 32'(run), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_timeout", 32'(timeout), 32'(0));
    check("rst_cycles", 32'(cycles), 32'(0));
    check("rst_gnt", 32'(host_gnt), 32'(1));
    check("rst_mem_we", 32'(mem_we), 32'(1));
    check("rst_mem_addr", 32'(mem_addr), 32'h10);
    check("rst_mem_wdat", 32'(mem_wdat), 32'hA5);
    tick(2);
    reset = 1'b0;
    tick(1);
    // core_done ignored in IDLE
    check("idle_ignore_done", 32'(done), 32'(0));
    core_done = 1'b0;

    // Normal run: done in 10th RUN cycle -> cycles = 9.
    req = 1'b1;
    tick(1);
    check("crst_run", 32'(run), 32'(0));
    check("crst_gnt", 32'(host_gnt), 32'(0));
    check("crst_core_rst", 32'(core_rst), 32'(1));
    core_we = 1'b1; host_we = 1'b1;
    #1;
    check("crst_mem_we", 32'(mem_we), 32'(0));
    check("crst_mem_addr", 32'(mem_addr), 32'h33);
    tick(1);
    check("crst2_run", 32'(run), 32'(0));
    tick(1);
    check("run_start", 32'(run), 32'(1));
    check("run_core_rst", 32'(core_rst), 32'(0));
    sb.push_back('{to: 1'b0, cyc: CW'(9)});
    core_we = 1'b0;
    #1;
    check("run_host_we_blocked", 32'(mem_we), 32'(0));
    core_we = 1'b1;
    #1;
    check("run_core_we", 32'(mem_we), 32'(1));
    check("run_core_addr", 32'(mem_addr), 32'h33);
    check("run_core_wdat", 32'(mem_wdat), 32'h5C);
    tick(9);
    check("run_cycles9", 32'(cycles), 32'(9));
    core_done = 1'b1;
    tick(1);
    check("fin_done", 32'(done), 32'(1));
    check("fin_gnt", 32'(host_gnt), 32'(1));
    check("fin_core_rst", 32'(core_rst), 32'(1));
    core_done = 1'b0;
    // Handshake: req held high through FIN must not restart.
    tick(5);
    check("fin_hold_done", 32'(done), 32'(1));
    check("fin_hold_cycles", 32'(cycles), 32'(9));
    req = 1'b0;
    tick(1);
    check("idle_done_low", 32'(done), 32'(0));
    check("idle_cycles_kept", 32'(cycles), 32'(9));

    // Timeout: no core_done, 20 RUN cycles.
    req = 1'b1;
    tick(1);
    check("t_cycles_cleared", 32'(cycles), 32'(0));
    tick(2);
    check("t_run", 32'(run), 32'(1));
    sb.push_back('{to: 1'b1, cyc: CW'(20)});
    tick(19);
    check("t_pre", 32'(done), 32'(0));
    tick(1);
    check("t_timeout", 32'(timeout), 32'(1));
    check("t_done", 32'(done), 32'(1));
    check("t_cycles", 32'(cycles), 32'(20));
    req = 1'b0;
    tick(1);
    check("t_clear", 32'(timeout), 32'(0));

    // core_done coincides with budget exhaustion: FIN wins.
    req = 1'b1;
    tick(3);
    sb.push_back('{to: 1'b0, cyc: CW'(19)});
    tick(19);
    core_done = 1'b1;
    tick(1);
    check("tie_done", 32'(done), 32'(1));
    check("tie_timeout", 32'(timeout), 32'(0));
    check("tie_cycles", 32'(cycles), 32'(19));
    core_done = 1'b0; req = 1'b0;
    tick(1);

    // Asynchronous reset mid-run, then a full CRST on the next request.
    req = 1'b1;
    tick(3);
    tick(7);
    check("r_cycles7", 32'(cycles), 32'(7));
    #2;
    reset = 1'b1;
    #1;
    check("r_run", 32'(run), 32'(0));
    check("r_cycles", 32'(cycles), 32'(0));
    check("r_core_rst", 32'(core_rst), 32'(1));
    check("r_gnt", 32'(host_gnt), 32'(1));
    #3;
    reset = 1'b0;
    tick(1);
    check("r_crst_gnt", 32'(host_gnt), 32'(0));
    tick(1);
    check("r_crst_run", 32'(run), 32'(0));
    tick(1);
    check("r_run_again", 32'(run), 32'(1));
    sb.push_back('{to: 1'b0, cyc: CW'(0)});
    core_done = 1'b1;
    tick(1);
    check("r_fin", 32'(done), 32'(1));
    core_done = 1'b0; req = 1'b0;
    tick(2);

    check("sb_empty", 32'(sb.size()), 32'(0));
    check("done_events", 32'(n_done), 32'(4));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
